conv_pe_seq: RTL and testbench
==============================

# conv_pe_seq

Parametrised sequential multiply-accumulate processing element for the convolution layers. It accepts one job per handshake: a full multi-channel kernel window, its weights, and a bias. It then performs one signed MAC per cycle across all channels and taps using an internal step counter. It returns both the raw accumulator and a requantized, optionally ReLU'd, saturated output through a valid/ready handshake. It replaces externally-counted PEs and serves any kernel size and channel count.

## Interface
- DW, 8: signed data element width
- WW, 8: signed weight element width
- BW, 16: signed bias width
- KTAPS, 9: taps per channel (3x3 kernel)
- CH, 2: input channels per job
- ACCW, 20: signed accumulator width
- OW, 8: signed quantized output width
- SHIFT, 0: arithmetic right shift applied before quantization
- RELU, 0: 1 = clamp negative results to 0 on q_o
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  job offered
- in_ready  out  1  job accepted when in_valid & in_ready at clk edge
- data_i  in  CH*KTAPS*DW  element idx = ch*KTAPS+tap at bits [idx*DW +: DW]
- weight_i  in  CH*KTAPS*WW  same indexing, WW-wide elements
- bias_i  in  BW  signed bias
- out_valid  out  1  result available
- out_ready  in  1  result consumed when out_valid & out_ready at clk edge
- acc_o  out  ACCW  raw signed accumulator
- q_o  out  OW  requantized result

## Operation
- N = CH*KTAPS MAC steps per job. Step counter s runs 0..N-1. ch = s / KTAPS, tap = s % KTAPS (channel-major order).
- The FSM has three states: IDLE, RUN, DONE.
- in_ready = (state==IDLE) | (state==DONE & out_ready). It is combinational.
- On accept:
  - data_i, weight_i and bias_i are latched into internal registers. Inputs may change afterwards.
  - acc <= sign-extended bias_i.
  - s <= 0.
  - state <= RUN.
- RUN, each cycle:
  - acc <= acc + data[s]*weight[s] (signed DW x WW product, sign-extended to ACCW).
  - s <= s+1.
  - At s==N-1: state <= DONE.
- Accumulation wraps modulo 2^ACCW (two's complement), with no saturation. The defaults are sized so that 18 full-scale products plus the bias fit.
- DONE:
  - out_valid=1.
  - acc_o and q_o are held stable until the result is consumed.
  - Consumed without a new job: state <= IDLE.
  - Consumed with in_valid=1 on the same edge: the new job is accepted and state <= RUN.
- q_o derivation, in order:
  1. t = acc >>> SHIFT.
  2. If RELU and t<0, then t=0.
  3. Saturate to [-2^(OW-1), 2^(OW-1)-1].
- acc_o and q_o are registered. They are valid only while out_valid=1 and are don't-care otherwise.

## Timing
- Reset (asynchronous, any state including mid-RUN):
  - state=IDLE, s=0, acc=0.
  - out_valid=0, acc_o=0, q_o=0, in_ready=1.
  - Any in-flight job is discarded. No out_valid is produced for it.
- Latency: job accepted at edge E; out_valid rises after edge E+N (N=18 at defaults).
- Back-to-back with out_ready=1 and in_valid=1: one result every N+1 cycles.
- in_valid while in RUN, or while in DONE with out_ready=0: not accepted. The source holds its request.
- out_ready while not in DONE: ignored.

## Test plan
- All 18 data=1, all weights=1, bias=5, defaults, out_ready=1 -> out_valid exactly 18 cycles after accept, with acc_o=23 and q_o=23.
- All data=-128, all weights=127, bias=-32768 -> acc_o=-325376 and q_o=-128. With RELU=1, q_o=0.
- Indexing check: all zero except data[ch1,tap4]=-7 and weight[ch1,tap4]=3, bias=0 -> acc_o=-21. With SHIFT=2, q_o=-6 (arithmetic shift floors).
- Backpressure: hold out_ready=0 for 5 cycles after out_valid rises -> out_valid, acc_o and q_o remain stable and in_ready=0. Raising out_ready completes the handshake, and in_ready follows the rule above.
- Back-to-back: in_valid held high with 3 distinct jobs and out_ready=1 -> results appear in order, spaced 19 cycles apart. Each new job is accepted on the same edge as the previous result is consumed.
- Assert rst_n low at step 10 of RUN -> all outputs 0 and in_ready=1 immediately. No out_valid for the aborted job. The next job computes correctly from bias.

Source files
------------

// File: rtl/conv_pe_seq_if.sv
// Job/result bus for the sequential convolution MAC PE.
// The PE connects as slave: it takes the job from the source and offers the result.
interface conv_pe_seq_if #(
    parameter int DW    = 8,
    parameter int WW    = 8,
    parameter int BW    = 16,
    parameter int KTAPS = 9,
    parameter int CH    = 2,
    parameter int ACCW  = 20,
    parameter int OW    = 8
);
    logic                        in_valid;
    logic                        in_ready;
    logic [CH*KTAPS*DW-1:0]      data_i;
    logic [CH*KTAPS*WW-1:0]      weight_i;
    logic signed [BW-1:0]        bias_i;
    logic                        out_valid;
    logic                        out_ready;
    logic signed [ACCW-1:0]      acc_o;
    logic signed [OW-1:0]        q_o;

    modport master (
        output in_valid, data_i, weight_i, bias_i, out_ready,
        input  in_ready, out_valid, acc_o, q_o
    );
    modport slave (
        input  in_valid, data_i, weight_i, bias_i, out_ready,
        output in_ready, out_valid, acc_o, q_o
    );
endinterface

// File: rtl/conv_pe_seq.sv
// Sequential MAC PE: latches a CH x KTAPS window plus bias, runs one signed MAC per
// cycle in channel-major order, then offers raw accumulator and requantized output.
module conv_pe_seq #(
    parameter int DW    = 8,
    parameter int WW    = 8,
    parameter int BW    = 16,
    parameter int KTAPS = 9,
    parameter int CH    = 2,
    parameter int ACCW  = 20,
    parameter int OW    = 8,
    parameter int SHIFT = 0,
    parameter int RELU  = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    conv_pe_seq_if.slave  bus
);
    localparam int N  = CH * KTAPS;
    localparam int SW = $clog2(N + 1);
    localparam logic [SW-1:0] LAST = SW'(N - 1);
    localparam logic signed [ACCW-1:0] QMAX = ACCW'((64'sd1 <<< (OW - 1)) - 64'sd1);
    localparam logic signed [ACCW-1:0] QMIN = ~QMAX;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e                     state_q, state_d;
    logic [SW-1:0]              s_q, s_d;
    logic signed [ACCW-1:0]     acc_q, acc_d, acc_sum;
    logic signed [OW-1:0]       q_q, q_d;
    logic [N-1:0][DW-1:0]       data_q;
    logic [N-1:0][WW-1:0]       weight_q;
    logic signed [DW+WW-1:0]    prod;
    logic                       accept;

    function automatic logic signed [OW-1:0] quant(input logic signed [ACCW-1:0] a);
        logic signed [ACCW-1:0] t;
        t = a >>> SHIFT;
        if (RELU != 0 && t[ACCW-1]) t = '0;
        if (t > QMAX)      t = QMAX;
        else if (t < QMIN) t = QMIN;
        return t[OW-1:0];
    endfunction

    assign prod    = $signed(data_q[s_q]) * $signed(weight_q[s_q]);
    assign acc_sum = acc_q + {{(ACCW-DW-WW){prod[DW+WW-1]}}, prod};

    assign bus.in_ready  = (state_q == IDLE) || (state_q == DONE && bus.out_ready);
    assign bus.out_valid = (state_q == DONE);
    assign bus.acc_o     = acc_q;
    assign bus.q_o       = q_q;
    assign accept        = bus.in_valid && bus.in_ready;

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        acc_d   = acc_q;
        q_d     = q_q;
        case (state_q)
            RUN: begin
                acc_d = acc_sum;
                s_d   = s_q + SW'(1);
                if (s_q == LAST) begin
                    state_d = DONE;
                    s_d     = '0;
                    q_d     = quant(acc_sum);
                end
            end
            DONE:    if (bus.out_ready && !bus.in_valid) state_d = IDLE;
            default: ;
        endcase
        // A new job overrides everything, including the DONE->IDLE drop.
        if (accept) begin
            state_d = RUN;
            s_d     = '0;
            acc_d   = {{(ACCW-BW){bus.bias_i[BW-1]}}, bus.bias_i};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            s_q      <= '0;
            acc_q    <= '0;
            q_q      <= '0;
            data_q   <= '0;
            weight_q <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            if (accept) begin
                data_q   <= bus.data_i;
                weight_q <= bus.weight_i;
            end
        end
    end
endmodule

// File: tb/tb_conv_pe_seq.sv
// Directed bench: three PEs (plain, RELU=1, SHIFT=2) driven with identical jobs.
module tb_conv_pe_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    conv_pe_seq_if if0 ();
    conv_pe_seq_if if1 ();
    conv_pe_seq_if if2 ();

    conv_pe_seq              u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    conv_pe_seq #(.RELU(1))  u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    conv_pe_seq #(.SHIFT(2)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2));

    typedef struct {
        logic signed [7:0]  d;
        logic signed [7:0]  w;
        int                 idx;   // -1: all elements = d/w; else only element idx nonzero
        logic signed [15:0] b;
        int                 acc;
        int                 q0;
        int                 qr;
        int                 qs;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic set_job(input vec_t v);
        logic [143:0] d;
        logic [143:0] w;
        for (int i = 0; i < 18; i++) begin
            d[i*8 +: 8] = (v.idx < 0 || v.idx == i) ? v.d : 8'sd0;
            w[i*8 +: 8] = (v.idx < 0 || v.idx == i) ? v.w : 8'sd0;
        end
        if0.data_i = d;  if1.data_i = d;  if2.data_i = d;
        if0.weight_i = w; if1.weight_i = w; if2.weight_i = w;
        if0.bias_i = v.b; if1.bias_i = v.b; if2.bias_i = v.b;
    endtask

    task automatic scramble();
        logic [143:0] r;
        for (int i = 0; i < 18; i++) r[i*8 +: 8] = 8'($urandom);
        if0.data_i = r;  if1.data_i = r;  if2.data_i = r;
        if0.weight_i = ~r; if1.weight_i = ~r; if2.weight_i = ~r;
        if0.bias_i = 16'($urandom); if1.bias_i = if0.bias_i; if2.bias_i = if0.bias_i;
    endtask

    task automatic drv_valid(input logic v);
        if0.in_valid = v; if1.in_valid = v; if2.in_valid = v;
    endtask

    task automatic drv_ready(input logic r);
        if0.out_ready = r; if1.out_ready = r; if2.out_ready = r;
    endtask

    task automatic wait_valid(output int cnt);
        cnt = 0;
        while (!if0.out_valid && cnt < 40) begin
            @(posedge clk); #1;
            cnt++;
        end
    endtask

    task automatic check_result(input vec_t v, input string tag);
        chk({tag, " acc_o"}, int'(if0.acc_o), v.acc);
        chk({tag, " q_o"}, int'(if0.q_o), v.q0);
        chk({tag, " q_o relu"}, int'(if1.q_o), v.qr);
        chk({tag, " q_o shift2"}, int'(if2.q_o), v.qs);
    endtask

    task automatic run_job(input vec_t v, input string tag);
        int cnt;
        set_job(v);
        drv_valid(1'b1);
        drv_ready(1'b1);
        @(posedge clk); #1;
        drv_valid(1'b0);
        scramble();
        wait_valid(cnt);
        chk({tag, " latency"}, cnt, 18);
        check_result(v, tag);
        @(posedge clk); #1;
        chk({tag, " out_valid drop"}, int'(if0.out_valid), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int cnt;
        int t_prev;
        int seen;
        vecs[0] = '{8'sd1,    8'sd1,    -1, 16'sd5,     23,      23,   23,   5};
        vecs[1] = '{8'sh80,   8'sd127,  -1, 16'sh8000,  -325376, -128, 0,    -128};
        vecs[2] = '{-8'sd7,   8'sd3,    13, 16'sd0,     -21,     -21,  0,    -6};
        vecs[3] = '{8'sd127,  8'sd127,  -1, 16'sd32767, 323089,  127,  127,  127};
        vecs[4] = '{8'sd2,    -8'sd3,   -1, 16'sd100,   -8,      -8,   0,    -2};
        vecs[5] = '{8'sh80,   8'sh80,   -1, 16'sd0,     294912,  127,  127,  127};
        vecs[6] = '{8'sd10,   8'sd5,    0,  -16'sd3,    47,      47,   47,   11};
        vecs[7] = '{-8'sd1,   8'sd1,    17, 16'sd0,     -1,      -1,   0,    -1};

        drv_valid(1'b0);
        drv_ready(1'b0);
        set_job(vecs[0]);
        repeat (2) @(posedge clk);
        #1;
        chk("reset out_valid", int'(if0.out_valid), 0);
        chk("reset acc_o", int'(if0.acc_o), 0);
        chk("reset q_o", int'(if0.q_o), 0);
        chk("reset in_ready", int'(if0.in_ready), 1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) run_job(vecs[i], $sformatf("vec%0d", i));

        // Backpressure: result held while the next job waits at the input.
        set_job(vecs[0]);
        drv_valid(1'b1);
        drv_ready(1'b0);
        @(posedge clk); #1;
        set_job(vecs[1]);
        wait_valid(cnt);
        chk("bp latency", cnt, 18);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp%0d out_valid", k), int'(if0.out_valid), 1);
            chk($sformatf("bp%0d acc_o", k), int'(if0.acc_o), 23);
            chk($sformatf("bp%0d q_o", k), int'(if0.q_o), 23);
            chk($sformatf("bp%0d in_ready", k), int'(if0.in_ready), 0);
            @(posedge clk); #1;
        end
        drv_ready(1'b1);
        #1;
        chk("bp in_ready on out_ready", int'(if0.in_ready), 1);
        @(posedge clk); #1;
        drv_valid(1'b0);
        chk("bp consumed", int'(if0.out_valid), 0);
        wait_valid(cnt);
        chk("bp next latency", cnt, 18);
        check_result(vecs[1], "bp next");
        @(posedge clk); #1;

        // Back-to-back: three jobs, in_valid held high throughout.
        set_job(vecs[3]);
        drv_valid(1'b1);
        @(posedge clk); #1;
        set_job(vecs[4]);
        wait_valid(cnt);
        chk("b2b first latency", cnt, 18);
        check_result(vecs[3], "b2b0");
        chk("b2b in_ready in DONE", int'(if0.in_ready), 1);
        t_prev = cyc;
        @(posedge clk); #1;
        set_job(vecs[5]);
        wait_valid(cnt);
        chk("b2b gap1", cyc - t_prev, 19);
        check_result(vecs[4], "b2b1");
        t_prev = cyc;
        @(posedge clk); #1;
        drv_valid(1'b0);
        wait_valid(cnt);
        chk("b2b gap2", cyc - t_prev, 19);
        check_result(vecs[5], "b2b2");
        @(posedge clk); #1;
        chk("b2b idle", int'(if0.out_valid), 0);

        // Reset in the middle of RUN.
        set_job(vecs[1]);
        drv_valid(1'b1);
        @(posedge clk); #1;
        drv_valid(1'b0);
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid-rst out_valid", int'(if0.out_valid), 0);
        chk("mid-rst acc_o", int'(if0.acc_o), 0);
        chk("mid-rst q_o", int'(if0.q_o), 0);
        chk("mid-rst in_ready", int'(if0.in_ready), 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        repeat (25) begin
            @(posedge clk); #1;
            if (if0.out_valid) seen = 1;
        end
        chk("aborted job no out_valid", seen, 0);
        run_job(vecs[6], "post-rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
